mul_result_combiner: RTL and testbench



---
 rtl/mul_result_combiner.sv | 139 +++++++++++++
 tb/tb_mul_result_combiner.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/mul_result_combiner.sv
// -----------------------------------------------------------------------------
// mul_result_combiner
//
// Reduces the three registered 16x16 partial products of the multiply cell to
// the low 32 bits of a 32x32 product:
//   result = p1 + ((p2[15:0] + p3[15:0]) << 16)   (mod 2^32)
// The upper halves of p2/p3 only contribute above bit 31 and are dropped.
// The block also carries an instruction valid bit and destination tag through
// an M -> A -> W pipeline that stalls with M_en and is killed by flush.
//
// Parameters:
//   DST_W    width of the destination register tag
//   OUT_REG  1: W stage registered (3 enabled edges issue->result)
//            0: W outputs driven combinationally from the A stage (2 edges)
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   M_en              pipeline advance enable (shared with the multiply cell)
//   flush             clears every valid bit, including the op entering M
//   E_mul_valid       multiply present in E stage
//   E_dst_regnum      its destination tag
//   M_mul_cell_p1..3  partial products, valid while the op sits in M
//   W_mul_result      low 32 bits of the product
//   W_mul_valid       W_mul_result/W_dst_regnum hold a live result
//   W_dst_regnum      destination tag of the result
//   mul_busy          any of M, A, W holds a live op
// -----------------------------------------------------------------------------
module mul_result_combiner #(
  parameter int unsigned DST_W   = 5,
  parameter bit          OUT_REG = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             M_en,
  input  logic             flush,
  input  logic             E_mul_valid,
  input  logic [DST_W-1:0] E_dst_regnum,
  input  logic [31:0]      M_mul_cell_p1,
  input  logic [31:0]      M_mul_cell_p2,
  input  logic [31:0]      M_mul_cell_p3,
  output logic [31:0]      W_mul_result,
  output logic             W_mul_valid,
  output logic [DST_W-1:0] W_dst_regnum,
  output logic             mul_busy
);

  // M stage: control only; the data for this stage lives in the multiply cell.
  logic             m_valid_q;
  logic [DST_W-1:0] m_dst_q;

  // A stage
  logic             a_valid_q;
  logic [DST_W-1:0] a_dst_q;
  logic [31:0]      a_p1_q;
  logic [15:0]      a_hi_q;

  logic [15:0] a_hi_d;
  logic [31:0] w_result_d;

  // 16-bit add: the carry out lands on bit 32 of the product and is dropped.
  assign a_hi_d     = M_mul_cell_p2[15:0] + M_mul_cell_p3[15:0];
  assign w_result_d = a_p1_q + {a_hi_q, 16'h0000};

  // Upper product halves only weigh in above bit 31.
  logic unused_upper_halves;
  assign unused_upper_halves = ^{M_mul_cell_p2[31:16], M_mul_cell_p3[31:16]};

  // Valid bits: flush wins over M_en so kills happen even during a stall.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values and stage ordering does not matter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid_q <= 1'b0;
      a_valid_q <= 1'b0;
    end else if (flush) begin
      m_valid_q <= 1'b0;
      a_valid_q <= 1'b0;
    end else if (M_en) begin
      m_valid_q <= E_mul_valid;
      a_valid_q <= m_valid_q;
    end
  end

  // Data and tags follow M_en only; invalid slots still compute.
  // NOTE: data registers are reset too, so outputs read as zero straight out
  // of reset and the datapath is deterministic even for dead slots.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_dst_q <= '0;
      a_dst_q <= '0;
      a_p1_q  <= '0;
      a_hi_q  <= '0;
    end else if (M_en) begin
      m_dst_q <= E_dst_regnum;
      a_dst_q <= m_dst_q;
      a_p1_q  <= M_mul_cell_p1;
      a_hi_q  <= a_hi_d;
    end
  end

  generate
    if (OUT_REG) begin : g_w_reg
      logic             w_valid_q;
      logic [DST_W-1:0] w_dst_q;
      logic [31:0]      w_result_q;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          w_valid_q <= 1'b0;
        end else if (flush) begin
          w_valid_q <= 1'b0;
        end else if (M_en) begin
          w_valid_q <= a_valid_q;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          w_dst_q    <= '0;
          w_result_q <= '0;
        end else if (M_en) begin
          w_dst_q    <= a_dst_q;
          w_result_q <= w_result_d;
        end
      end

      assign W_mul_valid  = w_valid_q;
      assign W_dst_regnum = w_dst_q;
      assign W_mul_result = w_result_q;
    end else begin : g_w_comb
      assign W_mul_valid  = a_valid_q;
      assign W_dst_regnum = a_dst_q;
      assign W_mul_result = w_result_d;
    end
  endgenerate

  assign mul_busy = m_valid_q | a_valid_q | W_mul_valid;

endmodule

// File: tb/tb_mul_result_combiner.sv
// -----------------------------------------------------------------------------
// tb_mul_result_combiner
//
// Directed bench for mul_result_combiner (DST_W=5, OUT_REG=1). The driver
// issues ops and, one enabled cycle later, the matching partial products,
// exactly as the multiply cell would. Each accepted op pushes its hand-computed
// result, tag and issue edge count into a queue; an independent monitor pops
// and compares whenever a new result appears on W.
// -----------------------------------------------------------------------------
module tb_mul_result_combiner;

  localparam int DST_W = 5;

  logic             clk;
  logic             reset_n;
  logic             M_en;
  logic             flush;
  logic             E_mul_valid;
  logic [DST_W-1:0] E_dst_regnum;
  logic [31:0]      M_mul_cell_p1;
  logic [31:0]      M_mul_cell_p2;
  logic [31:0]      M_mul_cell_p3;
  logic [31:0]      W_mul_result;
  logic             W_mul_valid;
  logic [DST_W-1:0] W_dst_regnum;
  logic             mul_busy;

  mul_result_combiner #(.DST_W(DST_W), .OUT_REG(1'b1)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .M_en          (M_en),
    .flush         (flush),
    .E_mul_valid   (E_mul_valid),
    .E_dst_regnum  (E_dst_regnum),
    .M_mul_cell_p1 (M_mul_cell_p1),
    .M_mul_cell_p2 (M_mul_cell_p2),
    .M_mul_cell_p3 (M_mul_cell_p3),
    .W_mul_result  (W_mul_result),
    .W_mul_valid   (W_mul_valid),
    .W_dst_regnum  (W_dst_regnum),
    .mul_busy      (mul_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      res;
    logic [DST_W-1:0] dst;
    int               cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   en_cnt = 0;

  // Products of the op currently in M (driven while it waits there).
  logic [31:0] pend_p1 = '0;
  logic [31:0] pend_p2 = '0;
  logic [31:0] pend_p3 = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, take the edge, then update the cell model.
  task automatic cyc(input logic en, input logic fl, input logic issue,
                     input logic [DST_W-1:0] dst,
                     input logic [31:0] np1, input logic [31:0] np2,
                     input logic [31:0] np3, input logic [31:0] exp_res);
    exp_t e;
    M_en          = en;
    flush         = fl;
    E_mul_valid   = issue;
    E_dst_regnum  = dst;
    M_mul_cell_p1 = pend_p1;
    M_mul_cell_p2 = pend_p2;
    M_mul_cell_p3 = pend_p3;
    @(posedge clk);
    #2;
    if (fl) q.delete();
    if (en) begin
      pend_p1 = issue ? np1 : 32'h0;
      pend_p2 = issue ? np2 : 32'h0;
      pend_p3 = issue ? np3 : 32'h0;
      if (issue && !fl) begin
        e.res = exp_res;
        e.dst = dst;
        e.cnt = en_cnt;
        q.push_back(e);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, '0, '0, '0, '0, '0);
  endtask

  // Monitor: a fresh result exists after every enabled edge with W valid.
  initial begin : monitor
    logic en_edge;
    exp_t e;
    forever begin
      @(posedge clk);
      en_edge = M_en && reset_n;
      if (en_edge) en_cnt++;
      @(negedge clk);
      if (reset_n && en_edge && W_mul_valid) begin
        if (q.size() == 0) begin
          check("unexpected_result", {31'b0, W_mul_valid}, 32'h0);
        end else begin
          e = q.pop_front();
          check("result", W_mul_result, e.res);
          check("dst_tag", {27'b0, W_dst_regnum}, {27'b0, e.dst});
          // Issue edge, A edge, W edge: W arrives two enabled edges after issue.
          check("latency", en_cnt - e.cnt, 32'd2);
        end
      end
    end
  end

  logic [31:0] snap_res;

  initial begin
    reset_n = 1'b0; M_en = 1'b0; flush = 1'b0; E_mul_valid = 1'b0;
    E_dst_regnum = '0; M_mul_cell_p1 = '0; M_mul_cell_p2 = '0; M_mul_cell_p3 = '0;
    #1;
    check("reset_result", W_mul_result, 32'h0);
    check("reset_valid",  {31'b0, W_mul_valid}, 32'h0);
    check("reset_dst",    {27'b0, W_dst_regnum}, 32'h0);
    check("reset_busy",   {31'b0, mul_busy}, 32'h0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;

    // Basic: 0x00010002 * 0x00030004
    cyc(1, 0, 1, 5'd7, 32'h8, 32'h6, 32'h4, 32'h000A0008);
    idle(4);

    // Wrap cases
    cyc(1, 0, 1, 5'd3, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'h00000001);
    cyc(1, 0, 1, 5'd4, 32'h0, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0000);
    idle(4);

    // Stall mid-pipe: issue, advance to A, then hold four cycles
    cyc(1, 0, 1, 5'd9, 32'h5, 32'h3, 32'h2, 32'h00050005);
    cyc(1, 0, 0, '0, '0, '0, '0, '0);
    snap_res = W_mul_result;
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, '0, '0, '0, '0, '0);
      check("stall_busy",   {31'b0, mul_busy}, 32'h1);
      check("stall_valid",  {31'b0, W_mul_valid}, 32'h0);
      check("stall_result", W_mul_result, snap_res);
    end
    cyc(1, 0, 0, '0, '0, '0, '0, '0);  // third enabled edge: result lands
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, '0, '0, '0, '0, '0);
      check("held_valid",  {31'b0, W_mul_valid}, 32'h1);
      check("held_result", W_mul_result, 32'h00050005);
      check("held_dst",    {27'b0, W_dst_regnum}, 32'd9);
    end
    idle(4);

    // Back-to-back, tags 1..4
    cyc(1, 0, 1, 5'd1, 32'h00001111, 32'h00000001, 32'h00000002, 32'h00031111);
    cyc(1, 0, 1, 5'd2, 32'h12345678, 32'hABCD0100, 32'h00000200, 32'h15345678);
    cyc(1, 0, 1, 5'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0000FFFF);
    cyc(1, 0, 1, 5'd4, 32'h0000ABCD, 32'h00008000, 32'h00008000, 32'h0000ABCD);
    cyc(1, 0, 0, '0, '0, '0, '0, '0);
    cyc(1, 0, 0, '0, '0, '0, '0, '0);
    check("b2b_valid_last", {31'b0, W_mul_valid}, 32'h1);
    idle(4);
    check("b2b_drained", q.size(), 32'h0);

    // Flush with ops in M, A, W and a fourth op in E
    cyc(1, 0, 1, 5'd10, 32'h1, 32'h1, 32'h1, 32'h00020001);
    cyc(1, 0, 1, 5'd11, 32'h2, 32'h2, 32'h2, 32'h00040002);
    cyc(1, 0, 1, 5'd12, 32'h3, 32'h3, 32'h3, 32'h00060003);
    cyc(1, 1, 1, 5'd13, 32'h4, 32'h4, 32'h4, 32'h00080004);
    check("flush_valid", {31'b0, W_mul_valid}, 32'h0);
    check("flush_busy",  {31'b0, mul_busy}, 32'h0);
    idle(5);
    check("flush_busy_after", {31'b0, mul_busy}, 32'h0);

    // Async reset between edges with ops in flight
    cyc(1, 0, 1, 5'd20, 32'h7, 32'h1, 32'h1, 32'h00020007);
    cyc(1, 0, 1, 5'd21, 32'h8, 32'h1, 32'h1, 32'h00020008);
    cyc(1, 0, 1, 5'd22, 32'h9, 32'h1, 32'h1, 32'h00020009);
    reset_n = 1'b0;
    #1;
    check("areset_result", W_mul_result, 32'h0);
    check("areset_valid",  {31'b0, W_mul_valid}, 32'h0);
    check("areset_dst",    {27'b0, W_dst_regnum}, 32'h0);
    check("areset_busy",   {31'b0, mul_busy}, 32'h0);
    q.delete();
    pend_p1 = '0; pend_p2 = '0; pend_p3 = '0;
    @(posedge clk);
    #2 reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(1, 0, 0, '0, '0, '0, '0, '0);
      check("post_reset_valid", {31'b0, W_mul_valid}, 32'h0);
    end

    check("pending_results", q.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
